// File: rtl/ps2_code_decoder_pkg.sv
// Shared PS/2 definitions: decoder state type, default prefix bytes and
// the prefix-transition helper used by the scan-code decoder.
package ps2_code_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT_E  = 2'd1,
    GOT_F  = 2'd2,
    GOT_EF = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;

  // Prefixes accumulate in either order; a repeated prefix keeps the state.
  function automatic ps2_state_e prefix_next(input ps2_state_e cur, input logic is_brk);
    ps2_state_e nxt;
    nxt = cur;
    unique case (cur)
      IDLE:    nxt = is_brk ? GOT_F  : GOT_E;
      GOT_E:   nxt = is_brk ? GOT_EF : GOT_E;
      GOT_F:   nxt = is_brk ? GOT_F  : GOT_EF;
      GOT_EF:  nxt = GOT_EF;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ps2_code_decoder_if.sv
// Byte-stream input and decoded-event output bundle of the PS/2 decoder.
interface ps2_code_decoder_if #(
  parameter int DATA_W = 8
);
  logic              rx_done;
  logic [DATA_W-1:0] din;
  logic              code_valid;
  logic [DATA_W-1:0] code;
  logic              ext;
  logic              brk;
  logic              rpt;
  logic              bandera;
  logic              err_tmo;

  modport master (
    output rx_done, din,
    input  code_valid, code, ext, brk, rpt, bandera, err_tmo
  );

  modport slave (
    input  rx_done, din,
    output code_valid, code, ext, brk, rpt, bandera, err_tmo
  );
endinterface

// File: rtl/ps2_code_decoder.sv
// PS/2 scan-code decoder: assembles make/break events from prefix bytes,
// marks typematic repeats and abandons stuck prefixes after a timeout.
module ps2_code_decoder
  import ps2_code_decoder_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] BRK_CODE    = DATA_W'(PS2_BRK_CODE),
  parameter logic [DATA_W-1:0] EXT_CODE    = DATA_W'(PS2_EXT_CODE),
  parameter int                TIMEOUT_CYC = 100000,
  parameter int                TMO_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input logic               clk,
  input logic               reset,
  ps2_code_decoder_if.slave bus
);

  ps2_state_e        state;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              lm_valid;
  logic              lm_ext;
  logic [DATA_W-1:0] lm_code;

  logic       is_brk;
  logic       is_prefix;
  logic       expire;
  logic       ev_ext;
  logic       ev_brk;
  logic       lm_hit;
  ps2_state_e pre_state;

  always_comb begin
    is_brk    = (bus.din == BRK_CODE);
    is_prefix = is_brk || (bus.din == EXT_CODE);
    expire    = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
    ev_ext    = (state == GOT_E) || (state == GOT_EF);
    ev_brk    = (state == GOT_F) || (state == GOT_EF);
    lm_hit    = (lm_ext == ev_ext) && (lm_code == bus.din);
    pre_state = prefix_next(state, is_brk);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      lm_valid       <= 1'b0;
      lm_ext         <= 1'b0;
      lm_code        <= '0;
      bus.code_valid <= 1'b0;
      bus.code       <= '0;
      bus.ext        <= 1'b0;
      bus.brk        <= 1'b0;
      bus.rpt        <= 1'b0;
      bus.bandera    <= 1'b0;
      bus.err_tmo    <= 1'b0;
    end else begin
      bus.code_valid <= 1'b0;
      bus.err_tmo    <= 1'b0;
      // An arriving byte takes priority over a timeout expiring this cycle.
      if (bus.rx_done) begin
        tmo_cnt <= '0;
        if (is_prefix) begin
          state       <= pre_state;
          bus.bandera <= (pre_state == GOT_F) || (pre_state == GOT_EF);
        end else begin
          state          <= IDLE;
          bus.bandera    <= 1'b0;
          bus.code_valid <= 1'b1;
          bus.code       <= bus.din;
          bus.ext        <= ev_ext;
          bus.brk        <= ev_brk;
          if (ev_brk) begin
            bus.rpt <= 1'b0;
            if (lm_hit) lm_valid <= 1'b0;
          end else begin
            bus.rpt  <= lm_valid && lm_hit;
            lm_valid <= 1'b1;
            lm_ext   <= ev_ext;
            lm_code  <= bus.din;
          end
        end
      end else if (expire) begin
        state       <= IDLE;
        tmo_cnt     <= '0;
        bus.bandera <= 1'b0;
        bus.err_tmo <= 1'b1;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/ps2_code_decoder.md
# ps2_code_decoder

Parametrised PS/2 scan-code decoder; successor to the single-purpose break flag. Sits after the PS/2 receiver, consumes its byte stream and done tick, and assembles complete make/break events with extended prefix, break prefix, typematic-repeat marking and a stuck-prefix timeout. Keeps the level `bandera` break-pending output so existing consumers keep working.

## Interface
- `DATA_W`, 8: width of received code byte.
- `BRK_CODE`, 8'hF0: break prefix value.
- `EXT_CODE`, 8'hE0: extended prefix value.
- `TIMEOUT_CYC`, 100000: clk cycles a pending prefix may wait for its next byte (≥2).
- `TMO_W`, $clog2(TIMEOUT_CYC+1): timeout counter width (derived).

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx_done` in 1: one-cycle strobe, `din` valid this cycle.
- `din` in DATA_W: received byte.
- `code_valid` out 1: one-cycle pulse, event outputs valid.
- `code` out DATA_W: final (non-prefix) byte of the event.
- `ext` out 1: event carried `EXT_CODE` prefix.
- `brk` out 1: event is a release.
- `rpt` out 1: make equal to last unreleased make (typematic repeat).
- `bandera` out 1: level; break prefix received, final byte pending.
- `err_tmo` out 1: one-cycle pulse, pending prefix abandoned by timeout.

## Operation
- FSM states: IDLE, GOT_E, GOT_F, GOT_EF. Bytes ignored unless `rx_done`=1.
- IDLE: `EXT_CODE`→GOT_E; `BRK_CODE`→GOT_F; other byte→emit make, stay IDLE.
- GOT_E: `BRK_CODE`→GOT_EF; `EXT_CODE`→stay (timer re-armed); other→emit make ext=1, →IDLE.
- GOT_F: `EXT_CODE`→GOT_EF (either prefix order accepted); `BRK_CODE`→stay (timer re-armed); other→emit break ext=0, →IDLE.
- GOT_EF: either prefix→stay (timer re-armed); other→emit break ext=1, →IDLE.
- Any byte not equal to a prefix (including E1) is a final byte.
- `bandera` = 1 exactly while state is GOT_F or GOT_EF.
- Last-make register {lm_valid, lm_ext, lm_code}: on emitted make, `rpt` = lm_valid & lm_ext==ext & lm_code==code, then register loads {1, ext, code}. On emitted break matching lm_ext/lm_code, lm_valid clears. `rpt`=0 on breaks.
- Timeout: counter cleared on entering/re-arming a non-IDLE state, increments each cycle while non-IDLE without `rx_done`; reaching `TIMEOUT_CYC` → IDLE, `err_tmo` pulse, no event emitted, last-make register untouched.
- Simultaneous `rx_done` and timeout expiry: byte wins, processed normally, no `err_tmo`.

## Timing
- Reset (async assert, sync-safe release): state IDLE, all outputs 0, timer 0, lm_valid 0.
- Event latency: `code_valid` and event fields registered, high the cycle after the `rx_done` carrying the final byte; fields hold until next event.
- `bandera` rises the cycle after the prefix `rx_done`; falls the cycle after the final-byte `rx_done` (same edge `code_valid` rises) or at timeout.
- `err_tmo` high the cycle after the counter reaches `TIMEOUT_CYC`.
- Back-to-back `rx_done` every cycle supported; no backpressure.
- Reset mid-sequence discards partial event; no output pulse.

## Structure
- Shared PS/2 package: state encoding type, default `BRK_CODE`/`EXT_CODE` constants (reused by receiver and host-to-device blocks).
- Single module; optional sub-module `ps2_prefix_timer` (load/clear, expire pulse) if reused by the receiver's frame watchdog.

## Test plan
- Reset held low mid-GOT_F → `bandera`=0, no `code_valid`; release, send 1C → make code=1C ext=0 brk=0 rpt=0.
- Send F0,1C → `bandera` 1 after F0, break code=1C brk=1; lm cleared, next 1C gives rpt=0.
- Send 1C,1C,1C → rpt=0,1,1; then E0,1C → ext=1 rpt=0.
- Send E0,F0,75 and F0,E0,75 → both: break code=75 ext=1 brk=1, `bandera` high during pending.
- Send F0 then idle `TIMEOUT_CYC` cycles → `err_tmo` single pulse, `bandera` falls, no event; next 1C → normal make.
- `rx_done` with 1C on exact expiry cycle after E0 → make ext=1, no `err_tmo`.
